// File: rtl/ex_cond_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_cond_pipe_pkg
// Description : Core-wide condition codes, flag-write indices and the
//               execute/memory control-word types.
// Revision    : 1.0  initial release
// ============================================================================
package ex_cond_pipe_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAGW_CV = 1;
    localparam int FLAGW_NZ = 0;

    localparam logic [3:0] BUBBLE_COND = COND_NV;

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic [1:0] flag_write;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_src;
    } e_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pc_src;
    } m_ctrl_t;

    // A bubble uses the "never" condition so it can touch neither flags nor state.
    function automatic e_ctrl_t e_bubble();
        e_ctrl_t b;
        b      = '0;
        b.cond = BUBBLE_COND;
        return b;
    endfunction

endpackage : ex_cond_pipe_pkg
`default_nettype wire

// File: rtl/ex_cond_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : ex_cond_pipe_sat_counter
// Description : Saturating up-counter with clear taking priority over count.
// Revision    : 1.0  initial release
// ============================================================================
module ex_cond_pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : ex_cond_pipe_sat_counter
`default_nettype wire

// File: rtl/ex_cond_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_cond_pipe
// Description : ID/EX and EX/MEM control registers around the condition
//               check, with annulment of failed instructions and a counter.
// Revision    : 1.0  initial release
// ============================================================================
module ex_cond_pipe
    import ex_cond_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond_D,
    input  logic [1:0]       FlagWrite_D,
    input  logic             RegWrite_D,
    input  logic             MemWrite_D,
    input  logic             MemtoReg_D,
    input  logic             PCSrc_D,
    input  logic             stall_E,
    input  logic             flush_E,
    input  logic             CondEx,
    input  logic             clr_cnt,
    output logic [3:0]       Cond_E,
    output logic [1:0]       FlagWrite_E,
    output logic             valid_E,
    output logic             RegWrite_M,
    output logic             MemWrite_M,
    output logic             MemtoReg_M,
    output logic             PCSrc_M,
    output logic             valid_M,
    output logic [CNT_W-1:0] annul_cnt
);

    e_ctrl_t r_e;
    m_ctrl_t r_m;
    e_ctrl_t w_e_load;
    m_ctrl_t w_m_next;
    logic    w_ok;
    logic    w_annul;

    always_comb begin
        w_e_load            = '0;
        w_e_load.valid      = 1'b1;
        w_e_load.cond       = Cond_D;
        w_e_load.flag_write = FlagWrite_D;
        w_e_load.reg_write  = RegWrite_D;
        w_e_load.mem_write  = MemWrite_D;
        w_e_load.mem_to_reg = MemtoReg_D;
        w_e_load.pc_src     = PCSrc_D;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e <= e_bubble();
        end else if (flush_E) begin
            r_e <= e_bubble();
        end else if (!stall_E) begin
            r_e <= w_e_load;
        end
    end

    assign w_ok = r_e.valid & CondEx;

    always_comb begin
        w_m_next            = '0;
        w_m_next.valid      = w_ok;
        w_m_next.reg_write  = r_e.reg_write & w_ok;
        w_m_next.mem_write  = r_e.mem_write & w_ok;
        w_m_next.pc_src     = r_e.pc_src & w_ok;
        w_m_next.mem_to_reg = r_e.mem_to_reg;
    end

    // A stalled E instruction stays put, so M takes a bubble rather than a copy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m <= '0;
        end else if (stall_E) begin
            r_m <= '0;
        end else begin
            r_m <= w_m_next;
        end
    end

    assign w_annul = r_e.valid & ~CondEx & ~stall_E;

    ex_cond_pipe_sat_counter #(
        .WIDTH (CNT_W)
    ) u_annul_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (w_annul),
        .cnt   (annul_cnt)
    );

    assign Cond_E      = r_e.cond;
    assign FlagWrite_E = r_e.flag_write;
    assign valid_E     = r_e.valid;
    assign RegWrite_M  = r_m.reg_write;
    assign MemWrite_M  = r_m.mem_write;
    assign MemtoReg_M  = r_m.mem_to_reg;
    assign PCSrc_M     = r_m.pc_src;
    assign valid_M     = r_m.valid;

endmodule : ex_cond_pipe
`default_nettype wire
